alu_seq_param: RTL and testbench

- Parametrised-width successor to the team's 4-bit signed combinational ALU.
- Keeps the 3-bit opcode map and flag semantics of that generation in the low opcodes, and adds shifts, an unsigned compare and an iterative multiply.
- Registers all results behind a valid/ready handshake on both sides.
- Sits between the decode stage and writeback in the NPC datapath experiments.

---
 rtl/alu_seq_param.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_seq_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// -----------------------------------------------------------------------------
// alu_seq_param
//
// Registered, parametrised-width ALU with a valid/ready handshake on both
// sides. Opcodes 0000-0111 follow the older 4-bit signed ALU: the same
// operations and the same flag meanings. Opcodes 1000-1100 add shifts, an
// iterative shift-add multiply and an unsigned compare.
//
// Handshake: an operation is taken on a rising edge where
// in_valid && in_ready. A result is handed over on a rising edge where
// out_valid && out_ready. out_valid and all result/flag outputs stay stable
// until that handover.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand/opcode valid
//   in_ready    block can accept an operation this cycle
//   A, B        operands (B[SHW-1:0] is the shift amount)
//   opt         4-bit opcode
//   out_valid   result and flags valid
//   out_ready   consumer takes result this cycle
//   result      registered result
//   carry_out   adder carry (1 = no borrow on subtract-type ops)
//   overflow    signed overflow of the adder
//   zero_flag   result == 0 (forced 0 for illegal opcodes)
//   less_flag   compare outcome for slt / sltu
//   equal_flag  A == B for eq
//   dbg_state_o current FSM state (IDLE=0, BUSY=1, DONE=2)
// -----------------------------------------------------------------------------
module alu_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero_flag,
    output logic             less_flag,
    output logic             equal_flag,
    output logic [1:0]       dbg_state_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] result_q;
    logic             carry_q, ovf_q, zero_q, less_q, equal_q;

    // Multiplier working registers
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;

    // ---------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs; only its value at
    // the accept edge is ever stored.
    // ---------------------------------------------------------------------
    logic             sub_type;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum;
    logic             add_c, add_v;
    logic [SHW-1:0]   sh_amt;

    assign sub_type = (opt == OP_SUB) || (opt == OP_SLT) ||
                      (opt == OP_EQ)  || (opt == OP_SLTU);
    // A - B is formed as A + ~B + 1, so carry=1 means "no borrow".
    assign b_op     = sub_type ? ~B : B;
    assign sum_ext  = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_type};
    assign sum      = sum_ext[WIDTH-1:0];
    assign add_c    = sum_ext[WIDTH];
    assign add_v    = (A[WIDTH-1] == b_op[WIDTH-1]) && (A[WIDTH-1] != sum[WIDTH-1]);
    assign sh_amt   = B[SHW-1:0];

    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_z, alu_l, alu_e, alu_legal;

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_l     = 1'b0;
        alu_legal = 1'b1;
        case (opt)
            OP_ADD, OP_SUB, OP_EQ: begin
                alu_res = sum;
                alu_c   = add_c;
                alu_v   = add_v;
            end
            OP_SLT: begin
                alu_res = sum;
                alu_c   = add_c;
                alu_v   = add_v;
                // Sign of the true difference, corrected for overflow.
                alu_l   = add_v ^ sum[WIDTH-1];
            end
            OP_SLTU: begin
                alu_res = sum;
                alu_c   = add_c;
                alu_v   = add_v;
                alu_l   = ~add_c;
            end
            OP_NOT:  alu_res = ~A;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLL:  alu_res = A << sh_amt;
            OP_SRL:  alu_res = A >> sh_amt;
            OP_SRA:  alu_res = WIDTH'($signed(A) >>> sh_amt);
            OP_MUL:  alu_res = '0;    // produced by the iterative path
            default: alu_legal = 1'b0; // illegal: everything stays 0
        endcase
        // Illegal opcodes report zero_flag=0 even though the result is 0.
        alu_z = alu_legal && (alu_res == '0);
        alu_e = (opt == OP_EQ) && alu_z;
    end

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    logic is_mul, accept, mul_last;
    logic [WIDTH-1:0] mul_acc_nxt;

    assign is_mul      = (opt == OP_MUL);
    assign accept      = in_valid && in_ready;
    assign mul_last    = (cnt_q == SHW'(WIDTH - 1));
    // Add the shifted multiplicand when the current multiplier LSB is set.
    assign mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = is_mul ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (mul_last) state_d = S_DONE;
            end
            S_DONE: begin
                // Result leaving this cycle frees the slot for a new op.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) state_d = is_mul ? S_BUSY : S_DONE;
                    else          state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            less_q   <= 1'b0;
            equal_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept && is_mul) begin
                mcand_q  <= A;
                mplier_q <= B;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (accept) begin
                result_q <= alu_res;
                carry_q  <= alu_c;
                ovf_q    <= alu_v;
                zero_q   <= alu_z;
                less_q   <= alu_l;
                equal_q  <= alu_e;
            end else if (state_q == S_BUSY) begin
                acc_q    <= mul_acc_nxt;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + SHW'(1);
                if (mul_last) begin
                    result_q <= mul_acc_nxt;
                    carry_q  <= 1'b0;
                    ovf_q    <= 1'b0;
                    zero_q   <= (mul_acc_nxt == '0);
                    less_q   <= 1'b0;
                    equal_q  <= 1'b0;
                end
            end
        end
    end

    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign carry_out   = carry_q;
    assign overflow    = ovf_q;
    assign zero_flag   = zero_q;
    assign less_flag   = less_q;
    assign equal_flag  = equal_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_param
//
// Directed bench for alu_seq_param at WIDTH=8. Each issued operation pushes
// its hand-computed response {result, carry, overflow, zero, less, equal}
// into exp_q; a monitor pops and compares on every output handover.
// Timing, hold and reset behaviour are compared inline by the main sequence.
// -----------------------------------------------------------------------------
module tb_alu_seq_param;

    localparam int W  = 8;
    localparam int EW = W + 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   opt = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry_out, overflow, zero_flag, less_flag, equal_flag;
    logic [1:0]   dbg_state_o;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .opt(opt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .carry_out(carry_out),
        .overflow(overflow),
        .zero_flag(zero_flag),
        .less_flag(less_flag),
        .equal_flag(equal_flag),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int tests  = 0;
    int failed = 0;

    function automatic logic [EW-1:0] mk(input logic [W-1:0] r, input logic c, v, z, l, e);
        return {r, c, v, z, l, e};
    endfunction

    function automatic logic [EW-1:0] dut_pkt();
        return {result, carry_out, overflow, zero_flag, less_flag, equal_flag};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(dut_pkt()), 64'hDEAD);
            end else begin
                check("out_pkt", 64'(dut_pkt()), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b,
                         input logic [EW-1:0] exp, input bit push);
        int n;
        opt      = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accept cycle until out_valid is seen (1 = next cycle).
    task automatic wait_valid(output int lat, input bit chk_busy, output bit ready_seen);
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (chk_busy && in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [EW-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int  lat;
        bit  rdy;
        logic [EW-1:0] mul_exp;

        //           result   c     v     z     l     e
        vecs.push_back('{4'h0, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)}); // add overflow
        vecs.push_back('{4'h1, 8'h00, 8'h01, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)}); // sub borrow
        vecs.push_back('{4'h1, 8'h05, 8'h05, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)}); // sub zero
        vecs.push_back('{4'h6, 8'h80, 8'h01, mk(8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)}); // slt
        vecs.push_back('{4'hC, 8'h80, 8'h01, mk(8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)}); // sltu
        vecs.push_back('{4'h7, 8'h3C, 8'h3C, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1)}); // eq
        vecs.push_back('{4'hA, 8'h90, 8'h0A, mk(8'hE4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)}); // sra, B[2:0]=2
        vecs.push_back('{4'h9, 8'h90, 8'h02, mk(8'h24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)}); // srl
        vecs.push_back('{4'h9, 8'h90, 8'h00, mk(8'h90, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)}); // shift by 0
        vecs.push_back('{4'h8, 8'h81, 8'h01, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)}); // sll
        vecs.push_back('{4'h2, 8'hFF, 8'h00, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)}); // not
        vecs.push_back('{4'h3, 8'hF0, 8'h3C, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)}); // and
        vecs.push_back('{4'h4, 8'h00, 8'h00, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)}); // or zero
        vecs.push_back('{4'h5, 8'hA5, 8'h5A, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)}); // xor
        vecs.push_back('{4'h0, 8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)}); // add carry
        vecs.push_back('{4'hD, 8'h00, 8'h00, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)}); // illegal
        vecs.push_back('{4'hF, 8'h12, 8'h34, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)}); // illegal

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_pkt", 64'(dut_pkt()), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // ---- single-cycle ops: latency 1 ----
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            wait_valid(lat, 1'b0, rdy);
            check($sformatf("latency_op%h", vecs[i].op), 64'(lat), 64'd1);
        end

        // ---- multiply with held consumer ----
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        mul_exp = mk(8'h8F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'hB, 8'h0D, 8'h0B, mul_exp, 1'b1);
        A   = 8'hFF;   // must not disturb the multiply in flight
        B   = 8'hFF;
        opt = 4'h0;
        wait_valid(lat, 1'b1, rdy);
        check("mul_latency", 64'(lat), 64'(W + 1));
        check("busy_in_ready_low", 64'(rdy), 64'd0);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_pkt", 64'(dut_pkt()), 64'(mul_exp));
            @(posedge clk);
            #1;
        end
        // Release and issue back-to-back in the same cycle.
        out_ready = 1'b1;
        issue(4'h0, 8'h01, 8'h01, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_result", 64'(result), 64'h02);

        // ---- reset in the middle of a multiply ----
        @(posedge clk);
        #1;
        issue(4'hB, 8'h0D, 8'h0B, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_mul_busy", 64'(dbg_state_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_pkt", 64'(dut_pkt()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        issue(4'h0, 8'h03, 8'h04, mk(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        wait_valid(lat, 1'b0, rdy);
        check("post_rst_latency", 64'(lat), 64'd1);

        // ---- drain and report ----
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
        @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
